// File: rtl/mips_regfile_if.sv
// Write-back / operand-read bundle between the pipeline and the MIPS register file.
// master = pipeline side (MEM/WB write, ID reads); slave = register file.
interface mips_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              re1_i;
  logic [ADDR_W-1:0] raddr1_i;
  logic [DATA_W-1:0] rdata1_o;
  logic              re2_i;
  logic [ADDR_W-1:0] raddr2_i;
  logic [DATA_W-1:0] rdata2_o;
  logic [31:0]       wr_cnt_o;

  modport master (
    output we_i, waddr_i, wdata_i,
    output re1_i, raddr1_i, re2_i, raddr2_i,
    input  rdata1_o, rdata2_o, wr_cnt_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i,
    input  re1_i, raddr1_i, re2_i, raddr2_i,
    output rdata1_o, rdata2_o, wr_cnt_o
  );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 MIPS register file: r0 hardwired to zero, two combinational read ports, write-commit counter.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module mips_regfile #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_REGS = 32
) (
  input logic          clk,
  input logic          rst,
  mips_regfile_if.slave rf
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [31:0]       wr_cnt_q;
  logic              commit;
  logic              hit1;
  logic              hit2;

  // Writes to r0 are dropped here, so r0 storage stays at its reset value.
  assign commit = rf.we_i && (rf.waddr_i != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else if (commit) begin
      regs_q[rf.waddr_i] <= rf.wdata_i;
      wr_cnt_q           <= wr_cnt_q + 32'd1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = commit && rf.re1_i && (rf.raddr1_i == rf.waddr_i);
  assign hit2 = commit && rf.re2_i && (rf.raddr2_i == rf.waddr_i);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    rf.rdata1_o = '0;
    if (rst && rf.re1_i && (rf.raddr1_i != '0)) begin
      rf.rdata1_o = hit1 ? rf.wdata_i : regs_q[rf.raddr1_i];
    end
  end

  always_comb begin
    rf.rdata2_o = '0;
    if (rst && rf.re2_i && (rf.raddr2_i != '0)) begin
      rf.rdata2_o = hit2 ? rf.wdata_i : regs_q[rf.raddr2_i];
    end
  end

  assign rf.wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: vector table through a scoreboard queue plus
// hand-written reset, bypass, counter-wrap and async-reset sequences.
module tb_mips_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  mips_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mips_regfile #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .rf  (bus.slave)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] ecnt;
  } exp_t;

  vec_t        tv [12];
  exp_t        sbq [$];
  int unsigned total;
  int unsigned bad;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    bus.we_i     = we;
    bus.waddr_i  = wa;
    bus.wdata_i  = wd;
    bus.re1_i    = re1;
    bus.raddr1_i = ra1;
    bus.re2_i    = re2;
    bus.raddr2_i = ra2;
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic re1, input logic [4:0] ra1,
                              input logic re2, input logic [4:0] ra2,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] ecnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd;
    v.re1 = re1; v.ra1 = ra1; v.re2 = re2; v.ra2 = ra2;
    v.e1 = e1; v.e2 = e2; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    #2 rst = 1'b0;
    #2 rst = 1'b1;
  endtask

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;

    // Expected outputs are the values seen before the edge that commits the row's write.
    tv[0]  = mk(1, 31, 32'hDEADBEEF, 1, 2,  1, 3,  32'h0, 32'h0, 0);
    tv[1]  = mk(1, 1,  32'h00000001, 1, 31, 1, 0,  32'hDEADBEEF, 32'h0, 1);
    tv[2]  = mk(0, 0,  32'h0,        1, 31, 1, 1,  32'hDEADBEEF, 32'h1, 2);
    tv[3]  = mk(0, 0,  32'h0,        0, 31, 1, 1,  32'h0, 32'h1, 2);
    tv[4]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  1, 0,  32'h0, 32'h0, 2);
    tv[5]  = mk(0, 0,  32'h0,        1, 0,  1, 0,  32'h0, 32'h0, 2);
    tv[6]  = mk(1, 10, 32'h00001234, 1, 10, 0, 10, BYP ? 32'h00001234 : 32'h0, 32'h0, 2);
    tv[7]  = mk(0, 0,  32'h0,        1, 10, 1, 10, 32'h00001234, 32'h00001234, 3);
    tv[8]  = mk(1, 10, 32'h5555AAAA, 1, 10, 1, 31, BYP ? 32'h5555AAAA : 32'h00001234, 32'hDEADBEEF, 3);
    tv[9]  = mk(0, 0,  32'h0,        1, 10, 1, 1,  32'h5555AAAA, 32'h1, 4);
    tv[10] = mk(1, 31, 32'h0,        1, 31, 1, 31, BYP ? 32'h0 : 32'hDEADBEEF, BYP ? 32'h0 : 32'hDEADBEEF, 4);
    tv[11] = mk(0, 0,  32'h0,        1, 31, 1, 10, 32'h0, 32'h5555AAAA, 5);

    rst = 1'b0;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd31);
    #1;
    check("reset_rd1", bus.rdata1_o, 32'h0);
    check("reset_rd2", bus.rdata2_o, 32'h0);
    check("reset_cnt", bus.wr_cnt_o, 32'h0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Reset clears the array immediately, then a fresh write lands.
    @(negedge clk);
    drive(1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("r5_first", bus.rdata1_o, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd0);
    #2 rst = 1'b0;
    #1;
    check("r5_in_reset", bus.rdata1_o, 32'h0);
    check("cnt_in_reset", bus.wr_cnt_o, 32'h0);
    #1 rst = 1'b1;
    #0.5;
    check("r5_after_rel", bus.rdata1_o, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd5, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("r5_rewrite", bus.rdata1_o, 32'hA5A5A5A5);
    check("cnt_rewrite", bus.wr_cnt_o, 32'h1);

    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].re1, tv[i].ra1, tv[i].re2, tv[i].ra2);
      sbq.push_back('{e1: tv[i].e1, e2: tv[i].e2, ecnt: tv[i].ecnt});
      #3;
      e = sbq.pop_front();
      check($sformatf("vec%0d_rd1", i), bus.rdata1_o, e.e1);
      check($sformatf("vec%0d_rd2", i), bus.rdata2_o, e.e2);
      check($sformatf("vec%0d_cnt", i), bus.wr_cnt_o, e.ecnt);
    end

    // Same-cycle write/read of r7.
    @(negedge clk);
    drive(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    check("r7_same_cycle", bus.rdata1_o, BYP ? 32'hCAFEF00D : 32'h0);
    @(posedge clk); #1;
    check("r7_after_edge", bus.rdata1_o, 32'hCAFEF00D);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    check("r7_stored", bus.rdata1_o, 32'hCAFEF00D);

    // Counter wrap from a deposited near-maximum value.
    @(negedge clk);
    dut.wr_cnt_q = 32'hFFFFFFFE;
    #1;
    check("cnt_preload", bus.wr_cnt_o, 32'hFFFFFFFE);
    @(negedge clk);
    drive(1'b1, 5'd2, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("cnt_max", bus.wr_cnt_o, 32'hFFFFFFFF);
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h22222222, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("cnt_wrap", bus.wr_cnt_o, 32'h0);
    @(negedge clk);
    drive(1'b1, 5'd0, 32'h33333333, 1'b0, 5'd0, 1'b0, 5'd0);
    @(posedge clk); #1;
    check("cnt_r0_write", bus.wr_cnt_o, 32'h0);

    // Async reset mid-cycle with a write to r3 pending; it spans an edge.
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h33333333, 1'b1, 5'd3, 1'b1, 5'd2);
    #2 rst = 1'b0;
    #1;
    check("async_rd1", bus.rdata1_o, 32'h0);
    check("async_rd2", bus.rdata2_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h44444444, 1'b1, 5'd3, 1'b1, 5'd4);
    #2 rst = 1'b1;
    #1;
    check("rel_r3", bus.rdata1_o, 32'h0);
    check("rel_cnt", bus.wr_cnt_o, 32'h0);
    @(posedge clk); #1;
    check("post_r4", bus.rdata2_o, 32'h44444444);
    check("post_cnt", bus.wr_cnt_o, 32'h1);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 5'd4);
    #1;
    check("final_r3", bus.rdata1_o, 32'h0);
    check("final_r4", bus.rdata2_o, 32'h44444444);
    check("final_r2_clr", dut.regs_q[2], 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
